// File: rtl/enp_bank_host.sv
// Command-side initiator for a collapse_bank: turns host INIT/READ commands into
// single-cycle bank strobes, waits out the read latency and returns one response each.
module enp_bank_host #(
    parameter int unsigned N        = 64,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned BASIS_W  = 8,
    parameter int unsigned ADDR_W   = $clog2(N),
    parameter int unsigned READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_value,
    input  logic [BASIS_W-1:0] cmd_basis,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_op,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_mismatch,
    output logic               rsp_empty,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  init_addr,
    output logic [DATA_W-1:0]  init_value,
    output logic [BASIS_W-1:0] init_basis,
    output logic               init_strobe,
    output logic [ADDR_W-1:0]  read_addr,
    output logic [BASIS_W-1:0] basis_in,
    output logic               read_pulse,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [N-1:0]       mismatch_vec_i,
    output logic [N-1:0]       armed_o
);

    localparam int unsigned CNT_W   = 3;
    localparam logic [1:0]  OP_INIT = 2'b01;
    localparam logic [1:0]  OP_READ = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        INIT_ISSUE,
        READ_ISSUE,
        READ_WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Single registered FSM; every output is a flop updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_op       <= '0;
            rsp_addr     <= '0;
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_empty    <= 1'b0;
            rsp_err      <= 1'b0;
            init_addr    <= '0;
            init_value   <= '0;
            init_basis   <= '0;
            init_strobe  <= 1'b0;
            read_addr    <= '0;
            basis_in     <= '0;
            read_pulse   <= 1'b0;
            armed_o      <= '0;
        end else begin
            init_strobe <= 1'b0;
            read_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        rsp_op       <= cmd_op;
                        rsp_addr     <= cmd_addr;
                        rsp_data     <= '0;
                        rsp_mismatch <= 1'b0;
                        rsp_empty    <= 1'b0;
                        rsp_err      <= 1'b0;
                        case (cmd_op)
                            OP_INIT: begin
                                init_addr         <= cmd_addr;
                                init_value        <= cmd_value;
                                init_basis        <= cmd_basis;
                                init_strobe       <= 1'b1;
                                armed_o[cmd_addr] <= 1'b1;
                                state             <= INIT_ISSUE;
                            end
                            OP_READ: begin
                                read_addr <= cmd_addr;
                                basis_in  <= cmd_basis;
                                // An unarmed cell was already consumed: answer without touching the bank.
                                if (armed_o[cmd_addr]) begin
                                    read_pulse        <= 1'b1;
                                    armed_o[cmd_addr] <= 1'b0;
                                    state             <= READ_ISSUE;
                                end else begin
                                    rsp_empty <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    state     <= RESP;
                                end
                            end
                            default: begin
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                        endcase
                    end
                end
                INIT_ISSUE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                READ_ISSUE: begin
                    wait_cnt <= CNT_W'(READ_LAT - 1);
                    state    <= READ_WAIT;
                end
                READ_WAIT: begin
                    // Bank data is valid in the last wait cycle; read_addr is still held.
                    if (wait_cnt == '0) begin
                        rsp_data     <= data_i;
                        rsp_mismatch <= mismatch_vec_i[read_addr];
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/enp_bank_host.md
Name: enp_bank_host

Overview:
- Command-side initiator that drives a collapse_bank.
- Accepts INIT/READ commands from a host over a valid/ready channel and generates the bank's one-cycle init_strobe / read_pulse.
- Holds read_addr stable through the bank read latency, then captures the selected cell's data and mismatch flag.
- Returns one response per command over a valid/ready channel.
- Keeps an armed bitmap so a cell consumed by a read is never pulsed again until re-initialised.

Parameters:
- N, 64, number of bank cells.
- DATA_W, 256, cell data width.
- BASIS_W, 8, basis width.
- ADDR_W, $clog2(N), cell address width.
- READ_LAT, 1, cycles from read_pulse high to valid data_i / mismatch_vec_i; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  2'b01 INIT, 2'b10 READ, 2'b00 and 2'b11 illegal.
- cmd_addr  in  ADDR_W  target cell.
- cmd_value  in  DATA_W  INIT payload.
- cmd_basis  in  BASIS_W  INIT basis or READ basis.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_op  out  2  echo of the accepted cmd_op.
- rsp_addr  out  ADDR_W  echo of the accepted cmd_addr.
- rsp_data  out  DATA_W  READ data; 0 for INIT, empty and err responses.
- rsp_mismatch  out  1  mismatch_vec_i[addr] sampled with the data; 0 otherwise.
- rsp_empty  out  1  READ targeted an unarmed cell.
- rsp_err  out  1  illegal op.
- init_addr  out  ADDR_W  to bank.
- init_value  out  DATA_W  to bank.
- init_basis  out  BASIS_W  to bank.
- init_strobe  out  1  to bank; one-cycle pulse.
- read_addr  out  ADDR_W  to bank; feeds the bank's combinational data mux.
- basis_in  out  BASIS_W  to bank.
- read_pulse  out  1  to bank; one-cycle pulse.
- data_i  in  DATA_W  bank data_o.
- mismatch_vec_i  in  N  bank mismatch_ground_vec.
- armed_o  out  N  armed bitmap, for status.

Behaviour:
- Reset values (the cycle after rst is sampled high):
  - State IDLE.
  - All outputs 0, including armed_o, init_*, read_addr, basis_in and all strobes.
  - cmd_ready is 1 from the first cycle after reset is released.
- Reset has priority over every other event, in every state. A reset mid-command drops the command with no response.
- FSM states:
  - IDLE: cmd_ready=1.
  - INIT_ISSUE.
  - READ_ISSUE.
  - READ_WAIT.
  - RESP.
  - cmd_ready=0 in every state except IDLE.
- Command accepted in IDLE at cycle T; all command fields are registered at T.
- INIT:
  - At T+1, INIT_ISSUE drives init_strobe=1 with init_addr/value/basis = captured fields, and sets armed[addr].
  - At T+2, RESP presents rsp_valid with rsp_op=01 and rsp_data=0.
  - INIT to an already-armed cell is legal and re-arms it. The bank overwrites the cell.
- READ, armed cell:
  - At T+1, READ_ISSUE drives read_pulse=1 and basis_in=captured basis, and clears armed[addr].
  - READ_WAIT counts READ_LAT cycles.
  - data_i and mismatch_vec_i[addr] are sampled at cycle T+1+READ_LAT.
  - rsp_valid is asserted at T+2+READ_LAT.
- READ, unarmed cell:
  - No read_pulse is issued.
  - At T+1, RESP presents rsp_empty=1, rsp_data=0, rsp_mismatch=0.
- Illegal op:
  - No bank activity.
  - At T+1, RESP presents rsp_err=1 with all other response fields 0 except the rsp_op/rsp_addr echo.
- read_addr:
  - Loaded at acceptance of a READ.
  - Held unchanged through READ_WAIT and afterwards until the next READ is accepted.
  - INIT never alters it.
- basis_in follows the same hold rule as read_addr.
- init_addr, init_value and init_basis hold their last value; only init_strobe pulses.
- init_strobe and read_pulse:
  - Never high in the same cycle.
  - Each is high for exactly one cycle per command.
- RESP:
  - All rsp_* fields are stable while rsp_valid=1 && rsp_ready=0.
  - On the handshake cycle the FSM goes to IDLE, so cmd_ready=1 on the next cycle.
  - Minimum command spacing is therefore 3 cycles for INIT and 3+READ_LAT cycles for a pulsed READ.
- armed_o reflects the bitmap registered value, updated in the ISSUE cycle.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Reset, then INIT addr 5, value 256'hA5A5…A5, basis 8'h3C -> init_strobe high only at T+1 with matching fields; armed_o[5]=1; rsp_valid at T+2 with op=01, data=0, err=0, empty=0.
- READ addr 5, basis 8'h3C, bank model with READ_LAT=1 returning 256'hA5…A5 and mismatch=0 -> read_pulse only at T+1; read_addr=5 held through T+2; rsp_data=A5…A5 at T+3; armed_o[5]=0.
- Second READ addr 5 -> no read_pulse; rsp at T+1 with empty=1, data=0.
- READ of an armed cell with basis 8'hC3 and the bank model setting mismatch_vec_i[5]=1 -> rsp_mismatch=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> response fields constant, cmd_ready=0, no strobes; handshake then cmd_ready=1 on the next cycle.
- cmd_op=2'b11 -> rsp_err=1 at T+1, no strobe. Then INIT addr 7, READ addr 7 with rst asserted for one cycle during READ_WAIT -> all outputs 0 after reset, no response; a subsequent READ addr 7 returns empty=1.
